vga_colour_quantiser: RTL
=========================

// Module: vga_colour_quantiser
// PURPOSE
//  Parametrised colour-depth reducer/ditherer for the VGA output path. Takes a CHANNELS x IN_W pixel
//  stream with sync/DE, optionally truncates source depth, quantises to OUT_W bits per channel with
//  selectable dither (truncate, round, 4x4 ordered Bayer, Bayer + temporal rotation), and re-emits
//  syncs aligned to the pixels. Sits between the pattern generator and the DAC pins.
// PARAMETERS
//  IN_W      8  source bits per channel (>=4, > OUT_W)
//  OUT_W     4  output bits per channel (>=1)
//  CHANNELS  3  colour channels, channel 0 in LSBs of packed buses
//  HS_ACT    0  active level of hsync_in/hsync_out
//  VS_ACT    0  active level of vsync_in/vsync_out
// PORTS
//  clk        in   1                pixel clock
//  rst_n      in   1                async active-low reset
//  mode       in   2                0 truncate, 1 round, 2 Bayer 4x4, 3 Bayer + temporal
//  depth      in   clog2(IN_W)      significant source bits minus 1 (IN_W-1 = full depth)
//  pix_in     in   CHANNELS*IN_W    source pixel
//  de_in      in   1                active video
//  hsync_in   in   1                horizontal sync
//  vsync_in   in   1                vertical sync
//  pix_out    out  CHANNELS*OUT_W   quantised pixel
//  de_out     out  1                de_in delayed 2
//  hsync_out  out  1                hsync_in delayed 2
//  vsync_out  out  1                vsync_in delayed 2
//  frame_cnt  out  4                frame counter (temporal phase)
// BEHAVIOUR
//  Reset: clk and async active-low rst_n (async assert, sync deassert). While rst_n=0: pix_out=0,
//   de_out=0, hsync_out=HS_ACT inverted, vsync_out=VS_ACT inverted, frame_cnt=0, x/y=0,
//   mode_q=0, depth_q=IN_W-1.
//  Frame edge: cycle where vsync_in goes inactive->active. On it: frame_cnt+=1 (wraps 15->0),
//   y<=0, mode_q<=mode, depth_q<=depth. mode/depth changes elsewhere have no effect until next edge.
//  Position: x (2b) +1 each cycle de_in=1, cleared when de_in=0. y (2b) +1 on de_in falling edge.
//   Both wrap mod 4. Frame edge coincident with DE fall: clear wins.
//  Depth: depth_q clamped to IN_W-1; v = top depth_q+1 bits of channel replicated MSB-first to fill IN_W.
//  Quantise: p = v*(2^OUT_W-1) (IN_W+OUT_W bits); i = p>>IN_W; f = p[IN_W-1:0].
//   out = i + (f > thr), saturating at 2^OUT_W-1.
//  Threshold thr (IN_W bits), B = Bayer[y][x] of {0,8,2,10 / 12,4,14,6 / 3,11,1,9 / 15,7,13,5}:
//   mode0 all-ones (never bump); mode1 2^(IN_W-1)-1; mode2 B<<(IN_W-4);
//   mode3 ((B + 5*frame_cnt) mod 16)<<(IN_W-4). Same thr for all channels.
//  Pipeline: stage1 registers v, thr, de/hs/vs; stage2 registers quantised result, de/hs/vs.
//   Latency exactly 2 cycles for pixels and syncs, no stalls.
//  de_out=0 forces pix_out=0 (blanking).
//  Input 0 -> 0 and input all-ones -> 2^OUT_W-1 in every mode.
// TESTING
//  1 rst_n low mid-line -> same edge pix_out=0, syncs inactive, frame_cnt=0; release -> first valid out 2 clks after de_in.
//  2 mode0 depth7 pix 0x808080 de=1 -> pix_out 0x777 at cycle+2; hs/vs/de pulses shifted exactly 2.
//  3 mode2 flat 0x80 field -> tile row0 = 8,7,8,7 per channel; row1 = 7,8,7,8; 8 of 16 pixels bumped.
//  4 mode3 0x80 at x=0,y=0 over frames with frame_cnt 0/1/2 -> 8/8/7 (thr 0/80/160).
//  5 mode 0->2 and depth 7->0 mid-frame -> no change until next vsync edge; then depth0 0x80 -> 0xF.
//  6 0xFF and 0x00 in modes 0..3 -> 0xF and 0x0; frame_cnt wraps 15->0 after 16 frames.

Source files
------------

// File: rtl/vga_colour_quantiser.sv
// Colour-depth reducer for the VGA output path: optional source-depth truncation, then
// quantisation to OUT_W bits with truncate/round/Bayer/temporal-Bayer dither, 2-cycle latency.
module vga_colour_quantiser #(
   parameter int   IN_W     = 8,
   parameter int   OUT_W    = 4,
   parameter int   CHANNELS = 3,
   parameter logic HS_ACT   = 1'b0,
   parameter logic VS_ACT   = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [1:0]                    mode,
   input  logic [$clog2(IN_W)-1:0]       depth,
   input  logic [CHANNELS*IN_W-1:0]      pix_in,
   input  logic                          de_in,
   input  logic                          hsync_in,
   input  logic                          vsync_in,
   output logic [CHANNELS*OUT_W-1:0]     pix_out,
   output logic                          de_out,
   output logic                          hsync_out,
   output logic                          vsync_out,
   output logic [3:0]                    frame_cnt
);

   localparam int              DW    = $clog2(IN_W);
   localparam int              NDEP  = 1 << DW;
   localparam int              PW    = IN_W + OUT_W;
   localparam logic [OUT_W-1:0] OMAX = '1;
   localparam logic [DW-1:0]   DFULL = DW'(IN_W - 1);

   // frame/position state
   logic          vs_prev_q, de_prev_q;
   logic [1:0]    x_q, y_q;
   logic [1:0]    mode_q;
   logic [DW-1:0] depth_q;
   logic [3:0]    frame_cnt_q;

   // pipeline state
   logic [CHANNELS*IN_W-1:0]  v_q, v_d;
   logic [IN_W-1:0]           thr_q, thr_d;
   logic                      de1_q, hs1_q, vs1_q;
   logic [CHANNELS*OUT_W-1:0] pix_q, pix_d;
   logic                      de2_q, hs2_q, vs2_q;

   logic frame_edge, de_fall;
   assign frame_edge = (vsync_in == VS_ACT) && (vs_prev_q != VS_ACT);
   assign de_fall    = de_prev_q && !de_in;

   function automatic logic [3:0] bayer_at(input logic [1:0] yy, input logic [1:0] xx);
      logic [3:0] b;
      case ({yy, xx})
         4'd0:  b = 4'd0;   4'd1:  b = 4'd8;   4'd2:  b = 4'd2;   4'd3:  b = 4'd10;
         4'd4:  b = 4'd12;  4'd5:  b = 4'd4;   4'd6:  b = 4'd14;  4'd7:  b = 4'd6;
         4'd8:  b = 4'd3;   4'd9:  b = 4'd11;  4'd10: b = 4'd1;   4'd11: b = 4'd9;
         4'd12: b = 4'd15;  4'd13: b = 4'd7;   4'd14: b = 4'd13;  default: b = 4'd5;
      endcase
      return b;
   endfunction

   logic [3:0] bay, bay_t;
   always_comb begin
      bay   = bayer_at(y_q, x_q);
      bay_t = bay + {frame_cnt_q[1:0], 2'b00} + frame_cnt_q;
      thr_d = '1;
      case (mode_q)
         2'd0:    thr_d = '1;
         2'd1:    thr_d = {1'b0, {(IN_W-1){1'b1}}};
         2'd2:    thr_d = IN_W'(bay) << (IN_W - 4);
         default: thr_d = IN_W'(bay_t) << (IN_W - 4);
      endcase
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      // every possible depth is precomputed; depth codes beyond IN_W-1 fall back to full depth
      logic [NDEP-1:0][IN_W-1:0] rep;
      for (genvar gd = 0; gd < NDEP; gd++) begin : g_dep
         localparam int NB = (gd < IN_W) ? gd + 1 : IN_W;
         for (genvar gb = 0; gb < IN_W; gb++) begin : g_bit
            assign rep[gd][IN_W-1-gb] = pix_in[gi*IN_W + IN_W - 1 - (gb % NB)];
         end
      end
      assign v_d[gi*IN_W +: IN_W] = rep[depth_q];

      logic [IN_W-1:0]  v_ch;
      logic [PW-1:0]    prod;
      logic [OUT_W-1:0] ip, qv;
      logic             bump;
      assign v_ch = v_q[gi*IN_W +: IN_W];
      assign prod = PW'(v_ch) * PW'(OMAX);
      assign ip   = prod[PW-1:IN_W];
      assign bump = prod[IN_W-1:0] > thr_q;
      // full-scale input must reach full-scale output even when dither never bumps
      assign qv   = ((&v_ch) || (bump && (ip == OMAX))) ? OMAX : ip + OUT_W'(bump);
      assign pix_d[gi*OUT_W +: OUT_W] = de1_q ? qv : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_prev_q   <= ~VS_ACT;
         de_prev_q   <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         mode_q      <= '0;
         depth_q     <= DFULL;
         frame_cnt_q <= '0;
      end else begin
         vs_prev_q <= vsync_in;
         de_prev_q <= de_in;
         x_q       <= de_in ? x_q + 2'd1 : 2'd0;
         if (frame_edge) begin
            y_q         <= '0;
            frame_cnt_q <= frame_cnt_q + 4'd1;
            mode_q      <= mode;
            depth_q     <= depth;
         end else if (de_fall) begin
            y_q <= y_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         thr_q <= '1;
         de1_q <= 1'b0;
         hs1_q <= ~HS_ACT;
         vs1_q <= ~VS_ACT;
         pix_q <= '0;
         de2_q <= 1'b0;
         hs2_q <= ~HS_ACT;
         vs2_q <= ~VS_ACT;
      end else begin
         v_q   <= v_d;
         thr_q <= thr_d;
         de1_q <= de_in;
         hs1_q <= hsync_in;
         vs1_q <= vsync_in;
         pix_q <= pix_d;
         de2_q <= de1_q;
         hs2_q <= hs1_q;
         vs2_q <= vs1_q;
      end
   end

   assign pix_out   = pix_q;
   assign de_out    = de2_q;
   assign hsync_out = hs2_q;
   assign vsync_out = vs2_q;
   assign frame_cnt = frame_cnt_q;

endmodule
